reaction_game_ctrl: RTL and testbench

REACTION_GAME_CTRL -- requirements
Module: reaction_game_ctrl

---
 rtl/reaction_game_ctrl.sv | 132 +++++++++++++
 tb/tb_reaction_game_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game controller: random 1..8 timer-period delay, GO indicator,
// then measures the player's response in Clock cycles, with false-start and timeout detection.
module reaction_game_ctrl #(
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         RT_WIDTH  = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Button,
    input  logic                TmrDone,
    output logic                TmrEnable,
    output logic                TmrReset,
    output logic                GoLed,
    output logic [RT_WIDTH-1:0] ReactionTime,
    output logic                ResultValid,
    output logic                FalseStart,
    output logic                Timeout,
    output logic                Busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_WAIT   = 3'd2,
        S_GO     = 3'd3,
        S_RESULT = 3'd4,
        S_FALSE  = 3'd5
    } state_t;

    localparam logic [RT_WIDTH-1:0] RT_MAX = '1;
    localparam logic [RT_WIDTH-1:0] RT_ONE = {{(RT_WIDTH-1){1'b0}}, 1'b1};

    state_t              state_reg, state_next;
    logic                start_prev_reg, button_prev_reg;
    logic                start_edge, button_edge;
    logic [7:0]          lfsr_reg;
    logic                lfsr_fb;
    logic [3:0]          wait_cnt_reg, wait_cnt_next;
    logic [RT_WIDTH-1:0] rt_cnt_reg, rt_cnt_next, rt_plus1;
    logic [RT_WIDTH-1:0] reaction_time_reg, reaction_time_next;
    logic                timeout_reg, timeout_next;

    // Previous-value registers come out of reset high so a held level is not an edge.
    assign start_edge  = Start & ~start_prev_reg;
    assign button_edge = Button & ~button_prev_reg;

    assign lfsr_fb  = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
    assign rt_plus1 = (rt_cnt_reg == RT_MAX) ? RT_MAX : rt_cnt_reg + RT_ONE;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg         <= S_IDLE;
            start_prev_reg    <= 1'b1;
            button_prev_reg   <= 1'b1;
            lfsr_reg          <= LFSR_SEED;
            wait_cnt_reg      <= 4'd0;
            rt_cnt_reg        <= '0;
            reaction_time_reg <= '0;
            timeout_reg       <= 1'b0;
        end else begin
            state_reg         <= state_next;
            start_prev_reg    <= Start;
            button_prev_reg   <= Button;
            lfsr_reg          <= {lfsr_reg[6:0], lfsr_fb};
            wait_cnt_reg      <= wait_cnt_next;
            rt_cnt_reg        <= rt_cnt_next;
            reaction_time_reg <= reaction_time_next;
            timeout_reg       <= timeout_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        wait_cnt_next      = wait_cnt_reg;
        rt_cnt_next        = rt_cnt_reg;
        reaction_time_next = reaction_time_reg;
        timeout_next       = timeout_reg;
        case (state_reg)
            S_IDLE, S_RESULT, S_FALSE: begin
                if (start_edge) begin
                    state_next    = S_ARM;
                    wait_cnt_next = {1'b0, lfsr_reg[2:0]} + 4'd1;
                    timeout_next  = 1'b0;
                end
            end
            S_ARM: begin
                state_next = button_edge ? S_FALSE : S_WAIT;
            end
            S_WAIT: begin
                // A press always beats a coincident timer terminal pulse.
                if (button_edge) begin
                    state_next = S_FALSE;
                end else if (TmrDone) begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                    if (wait_cnt_reg == 4'd1) begin
                        state_next  = S_GO;
                        rt_cnt_next = '0;
                    end
                end
            end
            S_GO: begin
                rt_cnt_next = rt_plus1;
                if (button_edge) begin
                    state_next         = S_RESULT;
                    reaction_time_next = rt_plus1;
                    timeout_next       = 1'b0;
                end else if (rt_cnt_reg == RT_MAX) begin
                    state_next         = S_RESULT;
                    reaction_time_next = RT_MAX;
                    timeout_next       = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        TmrEnable   = (state_reg == S_WAIT);
        TmrReset    = (state_reg != S_WAIT);
        GoLed       = (state_reg == S_GO);
        Busy        = (state_reg == S_ARM) || (state_reg == S_WAIT) || (state_reg == S_GO);
        ResultValid = (state_reg == S_RESULT);
        FalseStart  = (state_reg == S_FALSE);
    end

    assign ReactionTime = reaction_time_reg;
    assign Timeout      = timeout_reg;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed bench for reaction_game_ctrl with a short-period delay-timer model
// and an independent LFSR model to predict the random wait length.
module tb_reaction_game_ctrl;

    localparam logic [7:0] SEED = 8'hA5;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Button = 1'b0;
    logic        TmrDone;
    logic        TmrEnable, TmrReset, GoLed, ResultValid, FalseStart, Timeout, Busy;
    logic [15:0] ReactionTime;

    logic [3:0]  tcnt;
    logic [7:0]  lfsr_m;
    int          checks = 0;
    int          errors = 0;

    reaction_game_ctrl #(.LFSR_SEED(SEED), .RT_WIDTH(16)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Button(Button), .TmrDone(TmrDone),
        .TmrEnable(TmrEnable), .TmrReset(TmrReset), .GoLed(GoLed),
        .ReactionTime(ReactionTime), .ResultValid(ResultValid), .FalseStart(FalseStart),
        .Timeout(Timeout), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    // Delay timer stand-in with a 16-cycle period.
    always @(posedge Clock) begin
        if (TmrReset) tcnt <= 4'd0;
        else if (TmrEnable) tcnt <= tcnt + 4'd1;
    end
    assign TmrDone = TmrEnable && (tcnt == 4'hF);

    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    always @(posedge Clock) lfsr_m <= Reset ? SEED : lfsr_step(lfsr_m);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic start_round(output int exp_n);
        exp_n = int'(lfsr_m[2:0]) + 1;
        Start = 1'b1;
    endtask

    // Step until GO or FALSE, counting ARM cycles and TmrDone pulses seen in WAIT.
    task automatic wait_go(input int exp_n, input bit press_last, output int dones, output int arms);
        bit fin;
        dones = 0;
        arms  = 0;
        fin   = 1'b0;
        for (int i = 0; i < 400 && !fin; i++) begin
            tick();
            Start = 1'b0;
            if (GoLed || FalseStart) begin
                fin = 1'b1;
            end else begin
                if (Busy && TmrReset) arms++;
                if (TmrEnable && TmrDone) begin
                    dones++;
                    if (press_last && dones == exp_n) Button = 1'b1;
                end
            end
        end
        check("round_reached_end", 32'(fin), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tmrreset"}, 32'(TmrReset), 32'd1);
        check({tag, "_idle_outs"}, {26'd0, TmrEnable, GoLed, ResultValid, FalseStart, Busy, Timeout}, 32'd0);
        check({tag, "_rt"}, 32'(ReactionTime), 32'd0);
    endtask

    initial begin
        int n, dones, arms, go_cycles;

        repeat (3) tick();
        check_reset_outputs("reset");
        Reset = 1'b0;

        // Round 1: start edge at cycle 10, respond on the 300th GO cycle.
        repeat (10) tick();
        start_round(n);
        wait_go(n, 1'b0, dones, arms);
        check("r1_go", 32'(GoLed), 32'd1);
        check("r1_dones", 32'(dones), 32'(n));
        check("r1_arm_cycles", 32'(arms), 32'd1);
        check("r1_busy_go", 32'(Busy), 32'd1);
        repeat (299) tick();
        check("r1_go_held", 32'(GoLed), 32'd1);
        Button = 1'b1;
        tick();
        Button = 1'b0;
        check("r1_valid", 32'(ResultValid), 32'd1);
        check("r1_rt", 32'(ReactionTime), 32'd300);
        check("r1_flags", {29'd0, Timeout, Busy, GoLed}, 32'd0);
        tick();

        // Round 2: LFSR[2:0]=010 at the start edge gives three timer periods; instant press.
        for (int i = 0; i < 300 && lfsr_m[2:0] != 3'b010; i++) tick();
        start_round(n);
        wait_go(3, 1'b0, dones, arms);
        check("r2_dones", 32'(dones), 32'd3);
        check("r2_arm_cycles", 32'(arms), 32'd1);
        Button = 1'b1;
        tick();
        Button = 1'b0;
        check("r2_rt_first_cycle", 32'(ReactionTime), 32'd1);
        check("r2_valid", 32'(ResultValid), 32'd1);
        tick();

        // Round 3: press coincident with the final TmrDone is a false start.
        start_round(n);
        wait_go(n, 1'b1, dones, arms);
        Button = 1'b0;
        check("r3_false", 32'(FalseStart), 32'd1);
        check("r3_no_go", 32'(GoLed), 32'd0);
        check("r3_valid_clear", 32'(ResultValid), 32'd0);
        check("r3_rt_held", 32'(ReactionTime), 32'd1);
        check("r3_dones", 32'(dones), 32'(n));
        repeat (20) tick();
        check("r3_still_false", {30'd0, FalseStart, GoLed}, 32'd2);

        // Round 4: no response, with a Start edge injected during GO.
        start_round(n);
        wait_go(n, 1'b0, dones, arms);
        check("r4_false_clear", 32'(FalseStart), 32'd0);
        go_cycles = 1;
        for (int i = 0; i < 70000 && GoLed; i++) begin
            Start = (i == 3);
            tick();
            if (GoLed) go_cycles++;
        end
        Start = 1'b0;
        check("r4_go_len_ok", 32'(go_cycles >= 65535 && go_cycles <= 65536), 32'd1);
        check("r4_valid", 32'(ResultValid), 32'd1);
        check("r4_timeout", 32'(Timeout), 32'd1);
        check("r4_rt_sat", 32'(ReactionTime), 32'h0000FFFF);
        tick();

        // Reset mid-WAIT.
        start_round(n);
        for (int i = 0; i < 10 && !TmrEnable; i++) begin
            tick();
            Start = 1'b0;
        end
        repeat (5) tick();
        check("mid_wait", 32'(TmrEnable), 32'd1);
        Reset = 1'b1;
        tick();
        check_reset_outputs("rst_wait");
        Reset = 1'b0;
        tick();

        // Reset mid-GO.
        start_round(n);
        wait_go(n, 1'b0, dones, arms);
        repeat (3) tick();
        check("mid_go", 32'(GoLed), 32'd1);
        Reset = 1'b1;
        tick();
        check_reset_outputs("rst_go");

        // Button held through reset into GO: no response until released and re-pressed.
        Button = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        start_round(n);
        wait_go(n, 1'b0, dones, arms);
        check("held_reach_go", 32'(GoLed), 32'd1);
        repeat (5) tick();
        check("held_no_edge", {30'd0, GoLed, ResultValid}, 32'd2);
        Button = 1'b0;
        tick();
        Button = 1'b1;
        tick();
        Button = 1'b0;
        check("repress_valid", 32'(ResultValid), 32'd1);
        check("repress_rt", 32'(ReactionTime), 32'd7);
        check("repress_timeout", 32'(Timeout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
